uart_tx_cmd_queue: RTL and testbench
====================================

Name: uart_tx_cmd_queue

Overview:
- Buffers command bytes produced by the game-control logic and feeds them, one at a time, to the UART transmit byte input (`dataIn_bits` / `dataIn_ready` pair).
- The UART treats any byte with bits[1:0] != 2'b00 as "valid". It retransmits for as long as such a byte is held.
- This block therefore presents each byte until the transmit-accept pulse, then drives 8'h00 for an inter-byte gap.
- It sits directly upstream of the UART and runs on the same UART clock (16 x baud).

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- GAP_CYCLES, 32, clock cycles of forced 8'h00 after each accepted byte; must be at least 1.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clock  in  1  UART clock (16 x baud); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  producer offers cmd_bits this cycle.
- cmd_bits  in  8  command byte; legal only if bits[1:0] != 2'b00.
- cmd_ready  out  1  queue can accept (level < DEPTH); combinational from level.
- err_invalid  out  1  one-cycle pulse: an offered byte had bits[1:0] == 2'b00 and was dropped.
- tx_bits  out  8  registered; drives the UART dataIn_bits input.
- tx_ready  in  1  UART dataIn_ready pulse (byte latched by the transmitter).
- busy  out  1  high when state != IDLE or level != 0.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sent_cnt  out  CNT_W  bytes accepted by the UART; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - tx_bits = 8'h00, level = 0, sent_cnt = 0, err_invalid = 0.
  - State = IDLE, read and write pointers = 0, gap counter = 0.
- Reset asserted mid-operation discards queued bytes and any byte in flight. tx_bits is 8'h00 on the first cycle after reset is sampled high.
- Push:
  - cmd_valid & cmd_ready & legal byte: write at wr_ptr, increment wr_ptr (wraps at DEPTH).
  - cmd_valid & illegal byte: no write; err_invalid = 1 next cycle. This applies regardless of cmd_ready.
  - cmd_valid & !cmd_ready (full) with a legal byte: byte dropped, no error flag. The producer must hold cmd_valid.
- State machine:
  - IDLE: if level != 0, then tx_bits <= mem[rd_ptr] and go to PRESENT; else tx_bits stays 8'h00.
  - PRESENT: hold tx_bits. On tx_ready = 1:
    - pop (rd_ptr++, wraps);
    - tx_bits <= 8'h00;
    - sent_cnt++;
    - gap counter <= GAP_CYCLES - 1;
    - go to GAP.
    - tx_ready while in IDLE or GAP is ignored.
  - GAP: tx_bits = 8'h00. Decrement the counter each cycle; when the counter is 0, go to IDLE.
- Gap length: exactly GAP_CYCLES cycles in GAP, then 1 cycle in IDLE before the next byte appears. Minimum spacing from tx_ready to the next non-zero tx_bits is GAP_CYCLES + 1 cycles.
- Latency: a push into an empty queue in IDLE at edge t gives level = 1 after t and tx_bits = byte after edge t+1.
- Level update:
  - push and pop in the same cycle: level unchanged.
  - when full: cmd_ready = 0 in that cycle, so the push is not accepted even though a pop occurs. The freed slot is visible next cycle.
- Ordering: strict FIFO. Pointer wrap must not reorder bytes.
- The head byte is not removed until the tx_ready pulse.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PRESENT, GAP);
  - constant UART_IDLE_BYTE = 8'h00;
  - function is_legal_cmd(byte) = byte[1:0] != 2'b00.
- One sub-module, uart_sync_fifo:
  - parameterised DEPTH x 8 storage, pointers and level;
  - push/pop ports with full/empty flags.
- The top level holds the FSM, gap counter, sent counter and validity check.

Test Plan:
1. Single byte: push 8'h05 into an empty queue. tx_bits = 8'h05 two cycles after the push edge and held; pulse tx_ready. Next cycle tx_bits = 8'h00 for 32 + 1 cycles; sent_cnt = 1; busy falls.
2. Ordering and wrap: push 8'h01, 8'h12, 8'h23, then 10 more bytes across pointer wrap. Ack each byte with tx_ready; tx_bits sequence matches push order exactly; sent_cnt = 13.
3. Full: push 8 legal bytes with no acks. level = 8, cmd_ready = 0, a 9th byte 8'h0D is not stored. One ack gives cmd_ready = 1 the next cycle; then 8'h0D is accepted and is last out.
4. Illegal byte: push 8'h04. err_invalid pulses for exactly 1 cycle, level unchanged, tx_bits stays 8'h00. Repeat with the queue full: err_invalid still pulses.
5. Spurious ack: pulse tx_ready during IDLE and during GAP. No pop, sent_cnt unchanged, state sequence unaffected.
6. Reset mid-PRESENT: with 3 bytes queued and tx_bits = 8'h07, assert reset for 1 cycle. Next cycle tx_bits = 8'h00, level = 0, sent_cnt = 0, state = IDLE. A fresh push 8'h09 is sent normally.

Source files
------------

// File: rtl/uart_tx_cmd_queue_pkg.sv
// Shared types, constants and helpers for the UART transmit command queue.
// Covers the presenter state encoding, the idle line byte and the legality test.
package uart_tx_cmd_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } tx_state_t;

    // The UART treats any byte with a non-zero low pair as valid, so 8'h00 is "nothing to send".
    localparam logic [7:0] UART_IDLE_BYTE = 8'h00;

    function automatic logic is_legal_cmd(input logic [7:0] cmd_byte);
        return cmd_byte[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with power-of-two depth, synchronous reset and an occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             push_en;
    logic             pop_en;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = level_q;

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cmd_queue.sv
// Queues command bytes and presents them one at a time to the UART byte input,
// holding each until the transmitter accepts it and then forcing an idle gap.
module uart_tx_cmd_queue
    import uart_tx_cmd_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [7:0]             cmd_bits,
    output logic                   cmd_ready,
    output logic                   err_invalid,
    output logic [7:0]             tx_bits,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       sent_cnt
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [7:0]       tx_bits_q;
    logic [7:0]       tx_bits_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [CNT_W-1:0] sent_q;
    logic [CNT_W-1:0] sent_d;
    logic             err_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    assign cmd_ready   = !fifo_full;
    assign fifo_push   = cmd_valid && cmd_ready && is_legal_cmd(cmd_bits);
    assign tx_bits     = tx_bits_q;
    assign err_invalid = err_q;
    assign sent_cnt    = sent_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_bits),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_bits_q <= UART_IDLE_BYTE;
            gap_q     <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_bits_q <= tx_bits_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            err_q     <= cmd_valid && !is_legal_cmd(cmd_bits);
        end
    end

    // The head byte stays in the FIFO until tx_ready; the pop and the gap start share that edge.
    always_comb begin
        state_d   = state_q;
        tx_bits_d = tx_bits_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    tx_bits_d = fifo_head;
                    state_d   = PRESENT;
                end else begin
                    tx_bits_d = UART_IDLE_BYTE;
                end
            end
            PRESENT: begin
                if (tx_ready) begin
                    fifo_pop  = 1'b1;
                    tx_bits_d = UART_IDLE_BYTE;
                    sent_d    = sent_q + CNT_W'(1);
                    gap_d     = GAP_W'(GAP_CYCLES - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                tx_bits_d = UART_IDLE_BYTE;
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                tx_bits_d = UART_IDLE_BYTE;
                state_d   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cmd_queue.sv
// Directed self-checking bench for uart_tx_cmd_queue with DEPTH=8 and GAP_CYCLES=32.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_cmd_queue;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_bits;
    logic        cmd_ready;
    logic        err_invalid;
    logic [7:0]  tx_bits;
    logic        tx_ready;
    logic        busy;
    logic [3:0]  level;
    logic [15:0] sent_cnt;

    int check_count = 0;
    int pass_count  = 0;

    uart_tx_cmd_queue #(
        .DEPTH      (8),
        .GAP_CYCLES (32),
        .CNT_W      (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_bits    (cmd_bits),
        .cmd_ready   (cmd_ready),
        .err_invalid (err_invalid),
        .tx_bits     (tx_bits),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .level       (level),
        .sent_cnt    (sent_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] bits, input logic ready);
        cmd_valid = valid;
        cmd_bits  = bits;
        tx_ready  = ready;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // Waits (bounded) for a non-idle byte, checks it, then acknowledges it.
    task automatic waitAndAck(input string tag, input logic [7:0] expected);
        int waited = 0;
        while (tx_bits == 8'h00 && waited < 80) begin
            step();
            waited++;
        end
        checkOutput({tag, "_byte"}, {24'h0, tx_bits}, {24'h0, expected});
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput({tag, "_after_ack"}, {24'h0, tx_bits}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq2 [13];
        logic [7:0] fill [8];
        int nonzero;

        seq2 = '{8'h01, 8'h12, 8'h23, 8'h31, 8'h42, 8'h53, 8'h61,
                 8'h72, 8'h83, 8'h91, 8'hA2, 8'hB3, 8'hC1};
        fill = '{8'h11, 8'h22, 8'h33, 8'h41, 8'h52, 8'h63, 8'h71, 8'h82};

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        step();
        step();
        reset = 1'b0;
        checkOutput("rst_tx_bits",  {24'h0, tx_bits}, 32'h0);
        checkOutput("rst_level",    {28'h0, level}, 32'h0);
        checkOutput("rst_sent_cnt", {16'h0, sent_cnt}, 32'h0);
        checkOutput("rst_err",      {31'h0, err_invalid}, 32'h0);
        checkOutput("rst_busy",     {31'h0, busy}, 32'h0);
        checkOutput("rst_ready",    {31'h0, cmd_ready}, 32'h1);

        $display("[TB] single byte");
        pushByte(8'h05);
        checkOutput("t1_level_after_push", {28'h0, level}, 32'h1);
        checkOutput("t1_tx_not_yet",       {24'h0, tx_bits}, 32'h0);
        step();
        checkOutput("t1_tx_presented",     {24'h0, tx_bits}, 32'h05);
        step();
        step();
        checkOutput("t1_tx_held",          {24'h0, tx_bits}, 32'h05);
        checkOutput("t1_busy_presenting",  {31'h0, busy}, 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_tx_after_ack", {24'h0, tx_bits}, 32'h0);
        checkOutput("t1_sent_cnt",     {16'h0, sent_cnt}, 32'h1);
        checkOutput("t1_level_popped", {28'h0, level}, 32'h0);
        checkOutput("t1_busy_in_gap",  {31'h0, busy}, 32'h1);
        nonzero = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            if (tx_bits != 8'h00) nonzero++;
        end
        checkOutput("t1_gap_quiet", nonzero, 32'h0);
        checkOutput("t1_busy_last_gap", {31'h0, busy}, 32'h1);
        step();
        checkOutput("t1_busy_fell", {31'h0, busy}, 32'h0);

        $display("[TB] ordering and wrap");
        doReset();
        for (int i = 0; i < 3; i++) pushByte(seq2[i]);
        for (int i = 0; i < 3; i++) waitAndAck($sformatf("t2_a%0d", i), seq2[i]);
        for (int i = 3; i < 11; i++) pushByte(seq2[i]);
        checkOutput("t2_level_full", {28'h0, level}, 32'h8);
        for (int i = 3; i < 11; i++) waitAndAck($sformatf("t2_b%0d", i), seq2[i]);
        for (int i = 11; i < 13; i++) pushByte(seq2[i]);
        for (int i = 11; i < 13; i++) waitAndAck($sformatf("t2_c%0d", i), seq2[i]);
        checkOutput("t2_sent_cnt", {16'h0, sent_cnt}, 32'd13);

        $display("[TB] full queue");
        doReset();
        for (int i = 0; i < 8; i++) pushByte(fill[i]);
        checkOutput("t3_level", {28'h0, level}, 32'h8);
        checkOutput("t3_ready_low", {31'h0, cmd_ready}, 32'h0);
        pushByte(8'h0D);
        checkOutput("t3_drop_level", {28'h0, level}, 32'h8);
        checkOutput("t3_drop_no_err", {31'h0, err_invalid}, 32'h0);
        checkOutput("t3_head", {24'h0, tx_bits}, 32'h11);
        applyStimulus(1'b1, 8'h0D, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3_pop_no_push_level", {28'h0, level}, 32'h7);
        checkOutput("t3_ready_back", {31'h0, cmd_ready}, 32'h1);
        pushByte(8'h0D);
        checkOutput("t3_level_refill", {28'h0, level}, 32'h8);
        for (int i = 1; i < 8; i++) waitAndAck($sformatf("t3_d%0d", i), fill[i]);
        waitAndAck("t3_last", 8'h0D);
        checkOutput("t3_sent_cnt", {16'h0, sent_cnt}, 32'd9);

        $display("[TB] illegal byte");
        doReset();
        pushByte(8'h04);
        checkOutput("t4_err_pulse", {31'h0, err_invalid}, 32'h1);
        checkOutput("t4_level", {28'h0, level}, 32'h0);
        checkOutput("t4_tx_idle", {24'h0, tx_bits}, 32'h0);
        step();
        checkOutput("t4_err_cleared", {31'h0, err_invalid}, 32'h0);
        for (int i = 0; i < 8; i++) pushByte(fill[i]);
        pushByte(8'h04);
        checkOutput("t4_full_err_pulse", {31'h0, err_invalid}, 32'h1);
        checkOutput("t4_full_level", {28'h0, level}, 32'h8);
        step();
        checkOutput("t4_full_err_cleared", {31'h0, err_invalid}, 32'h0);

        $display("[TB] spurious ack");
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5_idle_ack_cnt", {16'h0, sent_cnt}, 32'h0);
        checkOutput("t5_idle_ack_tx", {24'h0, tx_bits}, 32'h0);
        pushByte(8'h35);
        waitAndAck("t5_first", 8'h35);
        for (int i = 0; i < 4; i++) step();
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        pushByte(8'h46);
        checkOutput("t5_gap_ack_cnt", {16'h0, sent_cnt}, 32'h1);
        checkOutput("t5_gap_level", {28'h0, level}, 32'h1);
        for (int i = 0; i < 26; i++) step();
        checkOutput("t5_still_gap", {24'h0, tx_bits}, 32'h0);
        step();
        checkOutput("t5_next_on_time", {24'h0, tx_bits}, 32'h46);
        waitAndAck("t5_second", 8'h46);
        checkOutput("t5_sent_cnt", {16'h0, sent_cnt}, 32'h2);

        $display("[TB] reset mid-present");
        doReset();
        pushByte(8'h07);
        pushByte(8'h0B);
        pushByte(8'h0E);
        checkOutput("t6_presenting", {24'h0, tx_bits}, 32'h07);
        checkOutput("t6_level", {28'h0, level}, 32'h3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t6_rst_tx", {24'h0, tx_bits}, 32'h0);
        checkOutput("t6_rst_level", {28'h0, level}, 32'h0);
        checkOutput("t6_rst_cnt", {16'h0, sent_cnt}, 32'h0);
        checkOutput("t6_rst_busy", {31'h0, busy}, 32'h0);
        pushByte(8'h09);
        waitAndAck("t6_fresh", 8'h09);
        checkOutput("t6_sent_cnt", {16'h0, sent_cnt}, 32'h1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
